// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NREQ byte streams.
// An owner keeps the grant for a whole packet; an idle-hold timeout frees a stalled owner.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int DBIT         = 8,
  parameter int HOLD_TIMEOUT = 1024,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int HCW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*DBIT-1:0] req_data_i,
  input  logic [NREQ-1:0]      req_last_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 tx_start_o,
  output logic [DBIT-1:0]      din_o,
  input  logic                 tx_done_tick_i,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_e;

  state_e                    state_q, state_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic                      last_q, last_d;
  logic [HCW-1:0]            hold_cnt_q, hold_cnt_d;
  logic [DBIT-1:0]           din_q, din_d;
  logic [NREQ-1:0][DBIT-1:0] data_a;
  logic [IDW:0]              sum;
  logic                      found;
  logic [IDW-1:0]            win, next_ptr;

  assign data_a = req_data_i;

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (req_valid_i[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  assign next_ptr = (grant_q == IDW'(NREQ-1)) ? '0 : grant_q + 1'b1;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign req_ready_o[i] = !reset_i && req_valid_i[i] &&
      ((state_q == IDLE && found && win == IDW'(i)) ||
       (state_q == HOLD && grant_q == IDW'(i)));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    din_d      = din_q;
    case (state_q)
      IDLE: if (found) begin
        din_d   = data_a[win];
        last_d  = req_last_i[win];
        grant_d = win;
        state_d = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: if (tx_done_tick_i) begin
        if (last_q) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: if (req_valid_i[grant_q]) begin
        din_d      = data_a[grant_q];
        last_d     = req_last_i[grant_q];
        hold_cnt_d = '0;
        state_d    = SEND;
      end else if (hold_cnt_q == HCW'(HOLD_TIMEOUT-1)) begin
        // Stalled owner: abandon the packet and move the pointer past it.
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      din_q      <= din_d;
    end
  end

  assign tx_start_o = (state_q == SEND);
  assign busy_o     = (state_q != IDLE);
  assign din_o      = din_q;
  assign grant_id_o = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level round-robin model predicts
// the (owner, byte) sequence each tx_start must present.
module tb_uart_tx_arbiter;
  localparam int N = 4, DB = 8, HT = 8;

  logic                   clk = 1'b0, reset;
  logic [N-1:0]           rv, rl, ready;
  logic [N-1:0][DB-1:0]   rd;
  logic                   tx_start, done_a, done_m, busy, auto_done, stall_en;
  logic [DB-1:0]          din;
  logic [1:0]             gid;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(N), .DBIT(DB), .HOLD_TIMEOUT(HT)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(rv), .req_data_i(rd),
    .req_last_i(rl), .req_ready_o(ready), .tx_start_o(tx_start), .din_o(din),
    .tx_done_tick_i(done_a | done_m), .grant_id_o(gid), .busy_o(busy));

  typedef struct { int id; logic [DB-1:0] d; } exp_t;
  typedef struct packed { logic first; logic last; logic [DB-1:0] d; } byte_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  byte_t bq[N][$];
  int    stall[N];
  int    m_ptr, lat, viol = 0;
  int    n_pass = 0, n_tot = 0;
  logic  prev_start = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard monitor: every start pulse must match the next predicted byte.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      if (exp_q.size() == 0) check("unexpected_start", {24'd0, din}, 32'hFFFF_FFFF);
      else begin
        mon_e = exp_q.pop_front();
        check("start_id", {30'd0, gid}, mon_e.id);
        check("start_din", {24'd0, din}, {24'd0, mon_e.d});
      end
    end
    if ((tx_start && prev_start) || !$onehot0(ready) || (reset && ready != 0) ||
        (tx_start && ready != 0)) viol++;
    prev_start = tx_start;
  end

  // Serializer stand-in: one done pulse a random number of cycles after each start.
  initial begin
    done_a = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_done && tx_start && !reset) begin
        lat = $urandom_range(1, 6);
        repeat (lat) @(posedge clk);
        #1 done_a = 1'b1;
        @(posedge clk);
        #1 done_a = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic add_byte(input int i, input logic [DB-1:0] d, input logic f, input logic l);
    byte_t b;
    b.first = f; b.last = l; b.d = d;
    bq[i].push_back(b);
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (bq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Packet-level model: whole packets, owner chosen round-robin from m_ptr.
  task automatic build_exp();
    byte_t mq[N][$];
    byte_t b;
    int    sel;
    logic  more = 1'b1;
    for (int j = 0; j < N; j++) mq[j] = bq[j];
    while (more) begin
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && mq[(m_ptr + k) % N].size() != 0) sel = (m_ptr + k) % N;
      if (sel < 0) more = 1'b0;
      else begin
        do begin
          b = mq[sel].pop_front();
          exp_q.push_back('{sel, b.d});
        end while (!b.last && mq[sel].size() != 0);
        m_ptr = (sel + 1) % N;
      end
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() == 0) rv[i] = 1'b0;
      else if (!bq[i][0].first && stall[i] > 0) begin
        rv[i] = 1'b0;
        stall[i]--;
      end else begin
        rv[i] = 1'b1;
        rd[i] = bq[i][0].d;
        rl[i] = bq[i][0].last;
      end
    end
  endtask

  task automatic run_engine();
    int           cyc = 0;
    logic [N-1:0] hs;
    build_exp();
    auto_done = 1'b1;
    for (int i = 0; i < N; i++) stall[i] = 0;
    @(posedge clk); #1;
    drive_lanes();
    while ((pending() || busy || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      hs = rv & ready;
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++)
        if (hs[i]) begin
          void'(bq[i].pop_front());
          if (stall_en) stall[i] = $urandom_range(0, 3);
        end
      drive_lanes();
    end
    check("engine_drained", {31'd0, cyc < 20000}, 1);
    auto_done = 1'b0;
    rv = '0;
  endtask

  initial begin
    reset = 1'b1; rv = '1; rl = '0; rd = '0; done_m = 1'b0;
    auto_done = 1'b0; stall_en = 1'b0; m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", {28'd0, ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_start", {31'd0, tx_start}, 0);
    check("rst_din", {24'd0, din}, 0);
    check("rst_gid", {30'd0, gid}, 0);
    @(posedge clk); #1;
    reset = 1'b0; rv = '0;

    // Single byte from requester 2.
    exp_q.push_back('{2, 8'h5A});
    rv = 4'b0100; rd[2] = 8'h5A; rl = 4'b0100;
    @(negedge clk);
    check("sb_ready", {28'd0, ready}, 4'b0100);
    check("sb_nostart", {31'd0, tx_start}, 0);
    @(posedge clk); #1; rv = '0;
    @(negedge clk);
    check("sb_start", {31'd0, tx_start}, 1);
    @(posedge clk); #1;
    @(posedge clk); #1; done_m = 1'b1;
    @(negedge clk);
    check("sb_busy_at_done", {31'd0, busy}, 1);
    @(posedge clk); #1; done_m = 1'b0;
    @(negedge clk);
    check("sb_idle_after_done", {31'd0, busy}, 0);
    m_ptr = 3;

    // Pointer now at 3: requester 3 must beat requester 0.
    add_byte(0, 8'hA0, 1'b1, 1'b1);
    add_byte(3, 8'hA3, 1'b1, 1'b1);
    run_engine();

    // Stray done in IDLE.
    done_m = 1'b1;
    @(posedge clk); #1; done_m = 1'b0;
    @(negedge clk);
    check("stray_idle_busy", {31'd0, busy}, 0);
    check("stray_idle_start", {31'd0, tx_start}, 0);

    // Round robin from reset: 0,1,2,3,0.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; m_ptr = 0;
    add_byte(0, 8'h01, 1'b1, 1'b1); add_byte(0, 8'h05, 1'b1, 1'b1);
    add_byte(1, 8'h02, 1'b1, 1'b1); add_byte(2, 8'h03, 1'b1, 1'b1);
    add_byte(3, 8'h04, 1'b1, 1'b1);
    run_engine();

    // Packet lock: requester 1's three bytes go out before requester 0.
    add_byte(1, 8'h11, 1'b1, 1'b0); add_byte(1, 8'h22, 1'b0, 1'b0);
    add_byte(1, 8'h33, 1'b0, 1'b1); add_byte(0, 8'hAA, 1'b1, 1'b1);
    run_engine();

    // Hold timeout with a stray done inside HOLD; pointer is 1 so requester 3 wins.
    exp_q.push_back('{3, 8'h3C});
    rv = 4'b1001; rd[3] = 8'h3C; rl = 4'b0001; rd[0] = 8'h0F;
    @(negedge clk);
    check("to_first_grant", {28'd0, ready}, 4'b1000);
    @(posedge clk); #1; rv = 4'b0001;
    @(posedge clk); #1; done_m = 1'b1;
    @(posedge clk); #1; done_m = 1'b0;
    for (int k = 0; k < HT; k++) begin
      done_m = (k == 4);
      @(negedge clk);
      check("to_hold_busy", {31'd0, busy}, 1);
      check("to_hold_ready", {28'd0, ready}, 0);
      @(posedge clk); #1;
    end
    done_m = 1'b0;
    @(negedge clk);
    check("to_idle_busy", {31'd0, busy}, 0);
    check("to_grant_req0", {28'd0, ready}, 4'b0001);
    exp_q.push_back('{0, 8'h0F});
    @(posedge clk); #1; rv = '0;
    @(posedge clk); #1; done_m = 1'b1;
    @(posedge clk); #1; done_m = 1'b0;
    m_ptr = 1;

    // Reset during WAIT of a 2-byte packet.
    exp_q.push_back('{2, 8'h77});
    rv = 4'b0100; rd[2] = 8'h77; rl = '0;
    @(posedge clk); #1; rd[2] = 8'h88; rl[2] = 1'b1;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("rw_ready_in_reset", {28'd0, ready}, 0);
    @(posedge clk); #1; reset = 1'b0; rv = '0;
    @(negedge clk);
    check("rw_busy", {31'd0, busy}, 0);
    check("rw_din", {24'd0, din}, 0);
    check("rw_gid", {30'd0, gid}, 0);
    check("rw_start", {31'd0, tx_start}, 0);
    @(posedge clk); #1; done_m = 1'b1;
    @(posedge clk); #1; done_m = 1'b0;
    @(negedge clk);
    check("rw_late_done_busy", {31'd0, busy}, 0);
    check("rw_late_done_start", {31'd0, tx_start}, 0);
    check("rw_late_done_ready", {28'd0, ready}, 0);
    m_ptr = 0;

    // Randomized packets with short owner stalls.
    stall_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            add_byte(i, DB'($urandom), b == 0, b == len - 1);
        end
      end
      run_engine();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    check("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
